hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Parametrised hazard controller for the 5-stage pipeline. Replaces the purely combinational hazard unit.
- Detects load-use, branch and jump hazards, with a configurable number of load-use bubble cycles for slower data memory.
- Freezes the pipeline while a multi-cycle mul/div instruction occupies EX.
- Keeps a saturating stall-cycle performance counter.
- Drives PC, IF/ID and ID/EX write-enables and flushes.

Parameters:
- REG_W, 5: register address width.
- LOAD_STALL, 1: bubble cycles inserted per load-use hazard; legal range 1..15.
- MD_CYCLES, 4: cycles a mul/div instruction occupies EX; legal range 2..16.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- branch_hazard  in  1  taken branch resolved in EX.
- jump_hazard  in  1  jump decoded in ID.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_MulDiv  in  1  instruction in EX is a mul/div.
- ID_EX_Rt  in  REG_W  destination of the load in EX.
- IF_ID_Rs  in  REG_W  source register of the instruction in ID.
- IF_ID_Rt  in  REG_W  source register of the instruction in ID.
- perf_clr  in  1  synchronous clear of stall_cnt.
- PC_Wen  out  1  PC write enable.
- IF_Wen  out  1  IF/ID write enable.
- IF_Flush  out  1  zero IF/ID.
- ID_Flush  out  1  insert bubble into ID/EX.
- EX_Hold  out  1  hold ID/EX and stall the EX-stage pipeline register.
- stall_cnt  out  CNT_W  count of cycles with PC_Wen=0.

Behaviour:
- Definitions:
  - load_use = ID_EX_MemRead && ID_EX_Rt!=0 && (ID_EX_Rt==IF_ID_Rs || ID_EX_Rt==IF_ID_Rt).
  - stall = ~PC_Wen.
- State: FSM {RUN, LU_STALL, MD_BUSY} plus a 4-bit down-counter cnt. Outputs are combinational from state and inputs.
- Reset (reset=0, asynchronous):
  - state=RUN, cnt=0, stall_cnt=0.
  - Outputs forced to PC_Wen=1, IF_Wen=1, IF_Flush=0, ID_Flush=0, EX_Hold=0 while reset=0, regardless of state.
  - Reset asserted mid-stall aborts the stall immediately.
- RUN, priority highest first:
  1. branch_hazard: IF_Flush=1, ID_Flush=1, no stall, stay RUN. A coincident load_use, mul/div or jump is ignored, since its instruction is being squashed.
  2. ID_EX_MulDiv: PC_Wen=IF_Wen=0, EX_Hold=1, no flushes; next MD_BUSY, cnt=MD_CYCLES-2.
  3. load_use: PC_Wen=IF_Wen=0, ID_Flush=1, IF_Flush=0.
     - If LOAD_STALL==1, stay RUN.
     - Otherwise go to LU_STALL with cnt=LOAD_STALL-2.
  4. jump_hazard: IF_Flush=1.
  5. Otherwise all enables 1, all flushes 0.
- LU_STALL:
  - Outputs: PC_Wen=IF_Wen=0, ID_Flush=1, IF_Flush=0, EX_Hold=0.
  - If cnt==0, next RUN; else cnt--.
  - Total bubbles per hazard = LOAD_STALL exactly.
- MD_BUSY:
  - If cnt!=0: PC_Wen=IF_Wen=0, EX_Hold=1, flushes 0, cnt--.
  - If cnt==0 (release cycle): outputs as RUN rule 4/5 (jump flush allowed), next RUN.
  - ID_EX_MulDiv is ignored while in MD_BUSY.
  - Frozen cycles = MD_CYCLES-1; the instruction leaves EX after MD_CYCLES cycles.
- Inputs outside RUN:
  - branch_hazard outside RUN cannot legally occur (EX holds a bubble or a mul/div). It is ignored.
  - jump_hazard while stalled gives IF_Flush=0; the flush is issued once the pipeline releases.
  - Load-use hazards arising during MD_BUSY are re-evaluated in RUN after release.
- IF_Flush and stall never assert in the same cycle.
- stall_cnt:
  - perf_clr=1 clears stall_cnt to 0 on the edge, and clear takes priority over increment.
  - Otherwise stall_cnt increments on each edge where stall=1.
  - Saturates at 2^CNT_W-1 (no wrap).

Test Plan:
1. Reset: hold reset=0 with load_use inputs active -> PC_Wen=1, ID_Flush=0, stall_cnt=0. Release reset -> stall asserts in the same cycle.
2. Load-use, LOAD_STALL=1 then 3:
   - Inputs: ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8.
   - Required: exactly 1 (resp. 3) consecutive cycles of PC_Wen=0 and ID_Flush=1.
   - stall_cnt rises by 1 (resp. 3).
   - ID_EX_Rt=0 gives no stall.
3. Mul/div, MD_CYCLES=4: ID_EX_MulDiv=1 held -> 3 cycles of EX_Hold=1 and PC_Wen=0, then a release cycle with PC_Wen=1, then RUN. stall_cnt += 3.
4. Priority:
   - branch_hazard with load_use in the same cycle -> IF_Flush=1, ID_Flush=1, PC_Wen=1, no LU_STALL entry.
   - jump_hazard with load_use -> IF_Flush=0 during the stall, then IF_Flush=1 in the cycle after.
5. Mid-operation reset: pulse reset=0 during MD_BUSY with cnt=2 -> outputs idle immediately; state=RUN after release.
6. Counter, CNT_W=4: 20 stall cycles -> stall_cnt saturates at 15. perf_clr asserted during a stall -> reads 0 on the next cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch/jump flushes, mul/div EX freeze
// and a saturating count of cycles in which the PC is held.
module hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int LOAD_STALL = 1,
  parameter int MD_CYCLES  = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branch_hazard,
  input  logic             jump_hazard,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_MulDiv,
  input  logic [REG_W-1:0] ID_EX_Rt,
  input  logic [REG_W-1:0] IF_ID_Rs,
  input  logic [REG_W-1:0] IF_ID_Rt,
  input  logic             perf_clr,
  output logic             PC_Wen,
  output logic             IF_Wen,
  output logic             IF_Flush,
  output logic             ID_Flush,
  output logic             EX_Hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MD_BUSY  = 2'd2
  } state_t;

  // The first stall cycle is spent in RUN, so the counters preload two short.
  localparam logic [3:0] LU_INIT = 4'(LOAD_STALL - 2);
  localparam logic [3:0] MD_INIT = 4'(MD_CYCLES - 2);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       load_use;

  assign load_use = ID_EX_MemRead && (ID_EX_Rt != '0) &&
                    ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (branch_hazard) begin
          state_nxt = RUN;
        end else if (ID_EX_MulDiv) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = MD_INIT;
        end else if (load_use && (LOAD_STALL > 1)) begin
          state_nxt = LU_STALL;
          cnt_nxt   = LU_INIT;
        end
      end
      LU_STALL, MD_BUSY: begin
        if (cnt == '0) state_nxt = RUN;
        else           cnt_nxt   = cnt - 4'd1;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    PC_Wen   = 1'b1;
    IF_Wen   = 1'b1;
    IF_Flush = 1'b0;
    ID_Flush = 1'b0;
    EX_Hold  = 1'b0;
    case (state)
      RUN: begin
        if (branch_hazard) begin
          IF_Flush = 1'b1;
          ID_Flush = 1'b1;
        end else if (ID_EX_MulDiv) begin
          PC_Wen  = 1'b0;
          IF_Wen  = 1'b0;
          EX_Hold = 1'b1;
        end else if (load_use) begin
          PC_Wen   = 1'b0;
          IF_Wen   = 1'b0;
          ID_Flush = 1'b1;
        end else if (jump_hazard) begin
          IF_Flush = 1'b1;
        end
      end
      LU_STALL: begin
        PC_Wen   = 1'b0;
        IF_Wen   = 1'b0;
        ID_Flush = 1'b1;
      end
      MD_BUSY: begin
        // The release cycle lets a pending jump flush but not a new load-use stall.
        if (cnt != '0) begin
          PC_Wen  = 1'b0;
          IF_Wen  = 1'b0;
          EX_Hold = 1'b1;
        end else if (jump_hazard) begin
          IF_Flush = 1'b1;
        end
      end
      default: ;
    endcase
    if (!reset) begin
      PC_Wen   = 1'b1;
      IF_Wen   = 1'b1;
      IF_Flush = 1'b0;
      ID_Flush = 1'b0;
      EX_Hold  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (perf_clr) begin
      stall_cnt <= '0;
    end else if (!PC_Wen && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a default instance driven from a vector table, plus
// LOAD_STALL=3 and CNT_W=4 instances exercised by hand-written sequences.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       branch_hazard, jump_hazard, mem_read, mul_div, perf_clr;
  logic [4:0] ex_rt, id_rs, id_rt;

  logic        pc_a, ifw_a, iff_a, idf_a, exh_a;
  logic [15:0] cnt_a;
  logic [1:0]  st_a;
  logic        pc_b, ifw_b, iff_b, idf_b, exh_b;
  logic [15:0] cnt_b;
  logic [1:0]  st_b;
  logic        pc_c, ifw_c, iff_c, idf_c, exh_c;
  logic [3:0]  cnt_c;
  logic [1:0]  st_c;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       rst, br, jp, mr, md;
    logic [4:0] exrt, rs, rt;
    logic       clr;
    logic [4:0] exp_out;  // {PC_Wen, IF_Wen, IF_Flush, ID_Flush, EX_Hold}
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[24];
  logic [20:0] exp_q[$];

  hazard_ctrl dut_a (
    .clk(clk), .reset(reset), .branch_hazard(branch_hazard), .jump_hazard(jump_hazard),
    .ID_EX_MemRead(mem_read), .ID_EX_MulDiv(mul_div), .ID_EX_Rt(ex_rt),
    .IF_ID_Rs(id_rs), .IF_ID_Rt(id_rt), .perf_clr(perf_clr),
    .PC_Wen(pc_a), .IF_Wen(ifw_a), .IF_Flush(iff_a), .ID_Flush(idf_a),
    .EX_Hold(exh_a), .stall_cnt(cnt_a), .dbg_state(st_a)
  );

  hazard_ctrl #(.LOAD_STALL(3)) dut_b (
    .clk(clk), .reset(reset), .branch_hazard(branch_hazard), .jump_hazard(jump_hazard),
    .ID_EX_MemRead(mem_read), .ID_EX_MulDiv(mul_div), .ID_EX_Rt(ex_rt),
    .IF_ID_Rs(id_rs), .IF_ID_Rt(id_rt), .perf_clr(perf_clr),
    .PC_Wen(pc_b), .IF_Wen(ifw_b), .IF_Flush(iff_b), .ID_Flush(idf_b),
    .EX_Hold(exh_b), .stall_cnt(cnt_b), .dbg_state(st_b)
  );

  hazard_ctrl #(.CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .branch_hazard(branch_hazard), .jump_hazard(jump_hazard),
    .ID_EX_MemRead(mem_read), .ID_EX_MulDiv(mul_div), .ID_EX_Rt(ex_rt),
    .IF_ID_Rs(id_rs), .IF_ID_Rt(id_rt), .perf_clr(perf_clr),
    .PC_Wen(pc_c), .IF_Wen(ifw_c), .IF_Flush(iff_c), .ID_Flush(idf_c),
    .EX_Hold(exh_c), .stall_cnt(cnt_c), .dbg_state(st_c)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic drive(input logic rst, br, jp, mr, md,
                       input logic [4:0] exrt, rs, rt, input logic clr);
    reset = rst; branch_hazard = br; jump_hazard = jp; mem_read = mr;
    mul_div = md; ex_rt = exrt; id_rs = rs; id_rt = rt; perf_clr = clr;
  endtask

  task automatic drive_idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic drive_lu(input logic jp, input logic clr);
    drive(1'b1, 1'b0, jp, 1'b1, 1'b0, 5'd8, 5'd8, 5'd0, clr);
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    drive_idle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic rst, br, jp, mr, md,
                         input logic [4:0] exrt, rs, rt, input logic clr,
                         input logic [4:0] eo, input logic [15:0] ec);
    vecs[i] = '{rst, br, jp, mr, md, exrt, rs, rt, clr, eo, ec};
  endtask

  logic [20:0] exp_w;
  logic [7:0]  pat, pat2;

  initial begin
    // Vector table for the default instance (LOAD_STALL=1, MD_CYCLES=4)
    set_vec( 0, 0,0,0,1,0, 8,8,0, 0, 5'b11000, 0);  // reset holds outputs idle
    set_vec( 1, 1,0,0,1,0, 8,8,0, 0, 5'b00010, 0);  // stall right after release
    set_vec( 2, 1,0,0,0,0, 0,0,0, 0, 5'b11000, 1);
    set_vec( 3, 1,0,0,1,0, 0,0,0, 0, 5'b11000, 1);  // r0 never hazards
    set_vec( 4, 1,0,0,1,0, 8,3,8, 0, 5'b00010, 1);  // match on Rt
    set_vec( 5, 1,0,0,0,0, 0,0,0, 0, 5'b11000, 2);
    set_vec( 6, 1,1,1,1,1, 8,8,0, 0, 5'b11110, 2);  // branch beats everything
    set_vec( 7, 1,0,0,0,0, 0,0,0, 0, 5'b11000, 2);
    set_vec( 8, 1,0,1,1,0, 8,8,0, 0, 5'b00010, 2);  // jump deferred by stall
    set_vec( 9, 1,0,1,0,0, 0,0,0, 0, 5'b11100, 3);
    set_vec(10, 1,0,0,0,1, 0,0,0, 0, 5'b00001, 3);  // mul/div enters EX
    set_vec(11, 1,0,0,0,1, 0,0,0, 0, 5'b00001, 4);
    set_vec(12, 1,0,0,0,1, 0,0,0, 0, 5'b00001, 5);
    set_vec(13, 1,0,1,0,1, 0,0,0, 0, 5'b11100, 6);  // release cycle, jump flushes
    set_vec(14, 1,0,0,0,0, 0,0,0, 0, 5'b11000, 6);
    set_vec(15, 1,0,0,1,1, 8,8,0, 0, 5'b00001, 6);  // mul/div beats load-use
    set_vec(16, 1,0,1,1,0, 8,8,0, 0, 5'b00001, 7);
    set_vec(17, 1,0,1,1,0, 8,8,0, 0, 5'b00001, 8);
    set_vec(18, 1,0,1,1,0, 8,8,0, 0, 5'b11100, 9);  // release ignores load-use
    set_vec(19, 1,0,1,1,0, 8,8,0, 0, 5'b00010, 9);  // re-evaluated in RUN
    set_vec(20, 1,0,0,0,0, 0,0,0, 1, 5'b11000, 10);
    set_vec(21, 1,0,0,1,0, 8,8,0, 1, 5'b00010, 0);  // clear wins over increment
    set_vec(22, 1,0,0,0,0, 0,0,0, 0, 5'b11000, 0);
    set_vec(23, 1,0,1,0,0, 0,0,0, 0, 5'b11100, 0);

    drive_idle();
    reset = 1'b0;
    next_cycle();
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].rst, vecs[i].br, vecs[i].jp, vecs[i].mr, vecs[i].md,
            vecs[i].exrt, vecs[i].rs, vecs[i].rt, vecs[i].clr);
      exp_q.push_back({vecs[i].exp_out, vecs[i].exp_cnt});
      #2;
      exp_w = exp_q.pop_front();
      chk($sformatf("vec%0d_outs", i), {27'd0, pc_a, ifw_a, iff_a, idf_a, exh_a},
          {27'd0, exp_w[20:16]});
      chk($sformatf("vec%0d_stall_cnt", i), {16'd0, cnt_a}, {16'd0, exp_w[15:0]});
      next_cycle();
    end

    // LOAD_STALL=3: exactly three consecutive bubbles from a one-cycle hazard
    reset_pulse();
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) drive_lu(1'b0, 1'b0);
      else        drive_idle();
      #2;
      pat[i] = !pc_b && idf_b;
      next_cycle();
    end
    chk("ls3_bubble_pattern", {24'd0, pat}, 32'h07);
    chk("ls3_stall_cnt", {16'd0, cnt_b}, 32'd3);

    // LOAD_STALL=3: branch with load-use does not enter LU_STALL
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0);
    #2;
    chk("ls3_branch_outs", {29'd0, pc_b, iff_b, idf_b}, 32'b111);
    next_cycle();
    drive_idle();
    #2;
    chk("ls3_after_branch_pc", {31'd0, pc_b}, 32'd1);
    chk("ls3_after_branch_state", {30'd0, st_b}, 32'd0);
    next_cycle();

    // LOAD_STALL=3: jump during load-use stall flushes only after release
    pat = '0;
    pat2 = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive_lu(1'b1, 1'b0);
      else        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      #2;
      pat[i]  = iff_b;
      pat2[i] = pc_b;
      next_cycle();
    end
    chk("ls3_jump_flush_pattern", {24'd0, pat}, 32'h08);
    chk("ls3_jump_pc_pattern", {24'd0, pat2}, 32'h08);
    drive_idle();
    next_cycle();

    // Reset pulsed while mul/div is frozen with cnt=2
    reset_pulse();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    next_cycle();
    drive_idle();
    #2;
    chk("md_busy_state", {30'd0, st_a}, 32'd2);
    chk("md_busy_hold", {31'd0, exh_a}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midreset_outs", {27'd0, pc_a, ifw_a, iff_a, idf_a, exh_a}, 32'b11000);
    chk("midreset_state", {30'd0, st_a}, 32'd0);
    next_cycle();
    reset = 1'b1;
    #2;
    chk("post_reset_outs", {27'd0, pc_a, ifw_a, iff_a, idf_a, exh_a}, 32'b11000);
    chk("post_reset_state", {30'd0, st_a}, 32'd0);
    next_cycle();

    // CNT_W=4: saturation after 20 stall cycles, then clear during a stall
    reset_pulse();
    for (int i = 0; i < 20; i++) begin
      drive_lu(1'b0, 1'b0);
      next_cycle();
    end
    #2;
    chk("cnt4_saturated", {28'd0, cnt_c}, 32'd15);
    chk("cnt4_still_stalling", {31'd0, pc_c}, 32'd0);
    perf_clr = 1'b1;
    next_cycle();
    perf_clr = 1'b0;
    #2;
    chk("cnt4_cleared", {28'd0, cnt_c}, 32'd0);
    next_cycle();
    #2;
    chk("cnt4_counts_again", {28'd0, cnt_c}, 32'd1);
    drive_idle();
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
